// File: rtl/gray_rank_filter_3x3_pkg.sv
// Shared definitions for the 3x3 grey rank filter: rank modes, pipeline depth,
// per-pixel tag carried alongside the window, and a 3-input median helper.
package gray_rank_filter_3x3_pkg;

    localparam logic [1:0] MODE_MEDIAN = 2'd0;
    localparam logic [1:0] MODE_MIN    = 2'd1;
    localparam logic [1:0] MODE_MAX    = 2'd2;
    localparam logic [1:0] MODE_BYPASS = 2'd3;

    localparam int LAT = 4;

    typedef struct packed {
        logic       border;
        logic [1:0] mode;
    } pix_tag_t;

    typedef struct packed {
        logic vsync;
        logic valid;
        logic clken;
    } ctrl_t;

    // Operands are zero-extended by the caller; 32 bits covers any sample width in use.
    function automatic logic [31:0] med3(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
        if (a > b)
            return (b > c) ? b : ((a > c) ? c : a);
        else
            return (a > c) ? a : ((b > c) ? c : b);
    endfunction

endpackage

// File: rtl/gray_rank_filter_3x3_line_buffer.sv
// Two-row line store in a single RAM word {row1, row0}: each write pushes the old
// row0 sample into row1 and returns the pre-write word one cycle later.
module gray_rank_filter_3x3_line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] row1,
    output logic [DATA_W-1:0] row0
);

    logic [2*DATA_W-1:0] mem [DEPTH];
    logic [2*DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= {mem[addr][DATA_W-1:0], din};
            rd_q      <= mem[addr];
        end
    end

    assign row1 = rd_q[2*DATA_W-1:DATA_W];
    assign row0 = rd_q[DATA_W-1:0];

endmodule

// File: rtl/gray_rank_filter_3x3.sv
// 3x3 grey rank filter (median / min / max / bypass) with internal line buffers,
// border masking, per-frame mode latch and a sticky line-overflow flag.
module gray_rank_filter_3x3
    import gray_rank_filter_3x3_pkg::*;
#(
    parameter int               DATA_W       = 8,
    parameter int               IMG_W_MAX    = 1024,
    parameter int               ADDR_W       = 10,
    parameter logic [1:0]       MODE_DEFAULT = 2'd0,
    parameter logic [DATA_W-1:0] BORDER_VAL  = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          cfg_mode,
    input  logic                pre_gray_vsync,
    input  logic                pre_gray_valid,
    input  logic                pre_gray_clken,
    input  logic [DATA_W-1:0]   pre_gray_data,
    output logic                pos_gray_vsync,
    output logic                pos_gray_valid,
    output logic                pos_gray_clken,
    output logic [3*DATA_W-1:0] pos_pixel_data,
    output logic                err_line_ovf
);

    localparam int ROW_W = 12;
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W_MAX - 1);

    function automatic logic [DATA_W-1:0] max3(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        logic [DATA_W-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [DATA_W-1:0] min3(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        logic [DATA_W-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [DATA_W-1:0] mid3(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        return DATA_W'(med3(32'(a), 32'(b), 32'(c)));
    endfunction

    logic              vsync_d;
    logic              valid_d;
    logic [1:0]        mode_q;
    logic [ROW_W-1:0]  row_cnt;
    logic [ADDR_W-1:0] col_cnt;
    logic              accept;
    logic              frame_start;
    logic              line_end;

    assign accept      = pre_gray_valid & pre_gray_clken;
    assign frame_start = pre_gray_vsync & ~vsync_d;
    assign line_end    = ~pre_gray_valid & valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d      <= 1'b0;
            valid_d      <= 1'b0;
            mode_q       <= MODE_DEFAULT;
            row_cnt      <= '0;
            col_cnt      <= '0;
            err_line_ovf <= 1'b0;
        end else begin
            vsync_d <= pre_gray_vsync;
            valid_d <= pre_gray_valid;
            if (frame_start) begin
                mode_q       <= cfg_mode;
                row_cnt      <= '0;
                col_cnt      <= '0;
                err_line_ovf <= 1'b0;
            end else if (accept) begin
                // Once saturated, further pixels keep overwriting the last column.
                if (col_cnt == COL_LAST)
                    err_line_ovf <= 1'b1;
                else
                    col_cnt <= col_cnt + 1'b1;
            end else if (line_end) begin
                col_cnt <= '0;
                if (row_cnt != '1)
                    row_cnt <= row_cnt + 1'b1;
            end
        end
    end

    logic [DATA_W-1:0] ram_row1;
    logic [DATA_W-1:0] ram_row0;

    gray_rank_filter_3x3_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W_MAX),
        .ADDR_W (ADDR_W)
    ) u_line_buffer (
        .clk   (clk),
        .wr_en (accept),
        .addr  (col_cnt),
        .din   (pre_gray_data),
        .row1  (ram_row1),
        .row0  (ram_row0)
    );

    // Stage 0 holds the new sample and its tag while the line RAM read completes.
    logic              acc_d;
    logic [DATA_W-1:0] px_d;
    pix_tag_t          tag_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_d <= 1'b0;
            px_d  <= '0;
            tag_d <= '0;
        end else begin
            acc_d <= accept;
            if (accept) begin
                px_d         <= pre_gray_data;
                tag_d.border <= (row_cnt < ROW_W'(2)) || (col_cnt < ADDR_W'(2));
                tag_d.mode   <= mode_q;
            end
        end
    end

    // S1: window, row 0 = oldest line, column 2 = newest pixel.
    logic [DATA_W-1:0] win [3][3];
    pix_tag_t          s1_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
            s1_tag <= '0;
        end else if (acc_d) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= ram_row1;
            win[1][2] <= ram_row0;
            win[2][2] <= px_d;
            s1_tag    <= tag_d;
        end
    end

    // S2: per-row sort.
    logic [DATA_W-1:0] row_max [3];
    logic [DATA_W-1:0] row_mid [3];
    logic [DATA_W-1:0] row_min [3];
    logic [DATA_W-1:0] s2_ctr;
    pix_tag_t          s2_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                row_max[r] <= '0;
                row_mid[r] <= '0;
                row_min[r] <= '0;
            end
            s2_ctr <= '0;
            s2_tag <= '0;
        end else begin
            for (int r = 0; r < 3; r++) begin
                row_max[r] <= max3(win[r][0], win[r][1], win[r][2]);
                row_mid[r] <= mid3(win[r][0], win[r][1], win[r][2]);
                row_min[r] <= min3(win[r][0], win[r][1], win[r][2]);
            end
            s2_ctr <= win[1][1];
            s2_tag <= s1_tag;
        end
    end

    // S3: column reductions; the three middle terms bracket the true 9-sample median.
    logic [DATA_W-1:0] s3_max_of_mins;
    logic [DATA_W-1:0] s3_med_of_mids;
    logic [DATA_W-1:0] s3_min_of_maxs;
    logic [DATA_W-1:0] s3_gmin;
    logic [DATA_W-1:0] s3_gmax;
    logic [DATA_W-1:0] s3_ctr;
    pix_tag_t          s3_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_max_of_mins <= '0;
            s3_med_of_mids <= '0;
            s3_min_of_maxs <= '0;
            s3_gmin        <= '0;
            s3_gmax        <= '0;
            s3_ctr         <= '0;
            s3_tag         <= '0;
        end else begin
            s3_max_of_mins <= max3(row_min[0], row_min[1], row_min[2]);
            s3_med_of_mids <= mid3(row_mid[0], row_mid[1], row_mid[2]);
            s3_min_of_maxs <= min3(row_max[0], row_max[1], row_max[2]);
            s3_gmin        <= min3(row_min[0], row_min[1], row_min[2]);
            s3_gmax        <= max3(row_max[0], row_max[1], row_max[2]);
            s3_ctr         <= s2_ctr;
            s3_tag         <= s2_tag;
        end
    end

    ctrl_t ctrl_pipe [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++)
                ctrl_pipe[i] <= '0;
        end else begin
            ctrl_pipe[0] <= '{vsync: pre_gray_vsync, valid: pre_gray_valid, clken: pre_gray_clken};
            for (int i = 1; i < LAT; i++)
                ctrl_pipe[i] <= ctrl_pipe[i-1];
        end
    end

    // S4 is combinational off registered S3 state so the data lines up with ctrl_pipe.
    logic [DATA_W-1:0] median;
    logic [DATA_W-1:0] y;

    always_comb begin
        median = mid3(s3_max_of_mins, s3_med_of_mids, s3_min_of_maxs);
        case (s3_tag.mode)
            MODE_MIN:    y = s3_gmin;
            MODE_MAX:    y = s3_gmax;
            MODE_BYPASS: y = s3_ctr;
            default:     y = median;
        endcase
        if (s3_tag.border)
            y = BORDER_VAL;
    end

    assign pos_gray_vsync = ctrl_pipe[LAT-1].vsync;
    assign pos_gray_valid = ctrl_pipe[LAT-1].valid;
    assign pos_gray_clken = ctrl_pipe[LAT-1].clken;
    assign pos_pixel_data = pos_gray_valid ? {3{y}} : '0;

endmodule
